haar_cascade_sequencer: RTL and testbench
=========================================

# haar_cascade_sequencer

Sequences one detection window through the Haar cascade, stage by stage. For each stage it:

- drives the stage index to the stage-threshold lookup;
- tells the weak-classifier engine to start that stage;
- accumulates the signed weak-classifier votes;
- compares the stage sum against the threshold, exiting early on reject.

It sits between the window scheduler (`start`/`done`), the weak-classifier engine (`stage_start`/`wc_*`) and the threshold lookup (`stage_num`/`thresh_in`). Thresholds and votes are signed fixed point, Q(ACC_W-FRAC_W).FRAC_W. Example: stage 0 threshold 0.8227 → 211 at FRAC_W=8.

## Interface

Parameters:
- NUM_STAGES, 22, cascade depth
- STAGE_W, 5, stage index width
- ACC_W, 24, signed accumulator/threshold/vote width
- FRAC_W, 8, fractional bits (documentation only; no internal scaling)

Ports:
- Clk  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a window; sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE, no done
- busy  out  1  high in every state except IDLE
- stage_num  out  STAGE_W  current stage index to threshold lookup; stable from STAGE_INIT through COMPARE
- thresh_in  in  ACC_W signed  threshold for stage_num (combinational lookup); sampled in COMPARE
- stage_start  out  1  one-cycle pulse in STAGE_INIT
- wc_valid  in  1  vote beat valid
- wc_ready  out  1  high only in ACCUM
- wc_value  in  ACC_W signed  vote value
- wc_last  in  1  final vote of the current stage; always carried on a valid beat
- done  out  1  one-cycle pulse when the window is decided
- face  out  1  1 = all stages passed; held until next accepted start
- fail_stage  out  STAGE_W  rejecting stage index (0 on accept); held until next accepted start

## Operation

States: IDLE, STAGE_INIT, ACCUM, COMPARE, DONE.

- **IDLE:** when start=1, clear face and fail_stage, set stage_num=0, go to STAGE_INIT.
- **STAGE_INIT:** acc ← 0, stage_start=1, go to ACCUM.
- **ACCUM:** each beat with wc_valid & wc_ready does acc ← sat(acc + wc_value). A beat with wc_last also goes to COMPARE. If wc_valid=0, acc holds.
- **COMPARE:** acc ≥ thresh_in (signed; equality passes) is a pass.
  - Fail: face=0, fail_stage=stage_num, go to DONE.
  - Pass on stage NUM_STAGES-1: face=1, fail_stage=0, go to DONE.
  - Pass on any other stage: stage_num+1, go to STAGE_INIT.
- **DONE:** done=1 for one cycle, go to IDLE.

Arithmetic and rules:
- Saturation clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. No wrap-around.
- start is ignored outside IDLE.
- wc_* inputs are ignored outside ACCUM; the engine must hold them.
- A stage with zero votes is not supported: wc_last always rides on a beat.
- abort is honoured in every non-IDLE state and has priority over all transitions:
  - next state IDLE, busy=0, no done pulse;
  - face and fail_stage keep their previous values;
  - abort in IDLE has no effect.

## Timing

- **Reset values:** state IDLE, busy 0, stage_num 0, stage_start 0, wc_ready 0, done 0, face 0, fail_stage 0, acc 0. Reset asserted mid-window forces these immediately, without waiting for a clock edge.
- **start edge:** cycle t = start sampled; t+1 = STAGE_INIT (stage_start=1, busy=1); t+2 = first cycle with wc_ready=1.
- **Per stage:** cost is 2 + B cycles, where B = cycles spent in ACCUM including stall cycles.
- **Decision:** COMPARE is the cycle after the wc_last beat. done asserts the cycle after COMPARE. busy drops the cycle after done. start is accepted again on that cycle.
- **Output registering:** face and fail_stage are registered and valid from the done cycle onward.
- **Minimum window latency**, start to done, with one beat per stage: 3·NUM_STAGES + 1 cycles.

## Test plan

1. **Equality pass, then reject.** Start. Stage 0: beats 100, 111(last) against thresh 211 → pass. Stage 1: beats 1000, 700(last) against thresh 1781 → reject. Expect done once, face=0, fail_stage=1, and stage_start pulsed exactly twice.
2. **Full accept.** Every stage gets one beat of 30000 against thresholds ≤ 27091. Expect face=1, fail_stage=0, done exactly 67 cycles after start, and stage_num sequencing 0..21.
3. **Saturation.** Beats 8000000, 8000000 → acc 8388607. Beats -8000000, -8000000 → -8388608. With thresh 0 the first stage passes and the second fails.
4. **Stalls.** Toggle wc_valid 1-0-0-1 across beats 5, 6(last). Expect sum 11, no accumulation while wc_valid=0, and wc_ready=0 during COMPARE. A beat presented during COMPARE is not summed.
5. **Abort and start-while-busy.** Start pulse at stage 3 while busy → ignored. abort during ACCUM → busy=0 next cycle, no done, face/fail_stage unchanged. A fresh start then restarts at stage 0 with acc 0.
6. **Async reset.** Assert Reset between clock edges during stage 5 ACCUM. Expect all outputs at reset values before the next edge. After release, start runs normally from stage 0.

Source files
------------

// File: rtl/haar_cascade_sequencer.sv
// Haar cascade stage sequencer: walks one window through all stages,
// sums saturated weak-classifier votes and exits early on a stage reject.
module haar_cascade_sequencer #(
  parameter int NUM_STAGES = 22,
  parameter int STAGE_W    = 5,
  parameter int ACC_W      = 24,
  parameter int FRAC_W     = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic [STAGE_W-1:0]       stage_num,
  input  logic signed [ACC_W-1:0]  thresh_in,
  output logic                     stage_start,
  input  logic                     wc_valid,
  output logic                     wc_ready,
  input  logic signed [ACC_W-1:0]  wc_value,
  input  logic                     wc_last,
  output logic                     done,
  output logic                     face,
  output logic [STAGE_W-1:0]       fail_stage
);

  if (FRAC_W >= ACC_W) begin : g_bad_frac
    $error("FRAC_W must be smaller than ACC_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ACCUM,
    S_CMP,
    S_DONE
  } state_e;

  localparam logic signed [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [STAGE_W-1:0] LastStage = STAGE_W'(NUM_STAGES - 1);

  state_e                    state_q;
  logic [STAGE_W-1:0]        stage_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W:0]     sum_w;
  logic                      face_q;
  logic [STAGE_W-1:0]        fail_q;

  // One guard bit detects overflow; clamp instead of wrapping.
  always_comb begin
    sum_w = {acc_q[ACC_W-1], acc_q} + {wc_value[ACC_W-1], wc_value};
    acc_d = sum_w[ACC_W-1:0];
    if (sum_w[ACC_W] != sum_w[ACC_W-1]) begin
      acc_d = sum_w[ACC_W] ? AccMin : AccMax;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      acc_q   <= '0;
      face_q  <= 1'b0;
      fail_q  <= '0;
    end else if (abort && state_q != S_IDLE) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            face_q  <= 1'b0;
            fail_q  <= '0;
            stage_q <= '0;
            state_q <= S_INIT;
          end
        end
        S_INIT: begin
          acc_q   <= '0;
          state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          if (wc_valid) begin
            acc_q <= acc_d;
            if (wc_last) begin
              state_q <= S_CMP;
            end
          end
        end
        S_CMP: begin
          if (acc_q < thresh_in) begin
            face_q  <= 1'b0;
            fail_q  <= stage_q;
            state_q <= S_DONE;
          end else if (stage_q == LastStage) begin
            face_q  <= 1'b1;
            fail_q  <= '0;
            state_q <= S_DONE;
          end else begin
            stage_q <= stage_q + 1'b1;
            state_q <= S_INIT;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign stage_start = (state_q == S_INIT);
  assign wc_ready    = (state_q == S_ACCUM);
  assign done        = (state_q == S_DONE);
  assign stage_num   = stage_q;
  assign face        = face_q;
  assign fail_stage  = fail_q;

endmodule

// File: tb/tb_haar_cascade_sequencer.sv
// Directed bench for haar_cascade_sequencer: equality pass, full accept,
// saturation, stalls, abort, start-while-busy and async reset.
module tb_haar_cascade_sequencer;

  logic               Clk;
  logic               Reset;
  logic               start;
  logic               abort;
  logic               busy;
  logic [4:0]         stage_num;
  logic signed [23:0] thresh_in;
  logic               stage_start;
  logic               wc_valid;
  logic               wc_ready;
  logic signed [23:0] wc_value;
  logic               wc_last;
  logic               done;
  logic               face;
  logic [4:0]         fail_stage;

  logic signed [23:0] thr [32];
  int checks;
  int errors;
  int ss_cnt;
  int done_cnt;
  int cyc;
  int ss0;
  int d0;
  int c0;

  haar_cascade_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .stage_num  (stage_num),
    .thresh_in  (thresh_in),
    .stage_start(stage_start),
    .wc_valid   (wc_valid),
    .wc_ready   (wc_ready),
    .wc_value   (wc_value),
    .wc_last    (wc_last),
    .done       (done),
    .face       (face),
    .fail_stage (fail_stage)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign thresh_in = thr[stage_num];

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (stage_start) ss_cnt <= ss_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int v, input logic last);
    wc_valid = 1'b1;
    wc_value = 24'(v);
    wc_last  = last;
    step();
    wc_valid = 1'b0;
    wc_value = '0;
    wc_last  = 1'b0;
  endtask

  // From STAGE_INIT, pass n stages with one beat of 1 each (thr must be <= 1).
  task automatic pass_stages(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      beat(1, 1'b1);
      step();
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_stage"}, 32'(stage_num), 0);
    chk({tag, "_sstart"}, 32'(stage_start), 0);
    chk({tag, "_ready"}, 32'(wc_ready), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_face"}, 32'(face), 0);
    chk({tag, "_fail"}, 32'(fail_stage), 0);
  endtask

  initial begin
    checks = 0; errors = 0;
    ss_cnt = 0; done_cnt = 0; cyc = 0;
    Reset = 1'b1; start = 1'b0; abort = 1'b0;
    wc_valid = 1'b0; wc_value = '0; wc_last = 1'b0;
    for (int i = 0; i < 32; i++) thr[i] = '0;
    step();
    step();
    Reset = 1'b0;
    step();
    chk_reset_vals("rst");

    // 1: equality pass on stage 0, reject on stage 1
    thr[0] = 24'sd211;
    thr[1] = 24'sd1781;
    ss0 = ss_cnt; d0 = done_cnt;
    do_start();
    chk("t1_sstart", 32'(stage_start), 1);
    chk("t1_busy", 32'(busy), 1);
    step();
    chk("t1_ready", 32'(wc_ready), 1);
    beat(100, 1'b0);
    beat(111, 1'b1);
    chk("t1_cmp_ready", 32'(wc_ready), 0);
    step();
    chk("t1_stage1", 32'(stage_num), 1);
    step();
    beat(1000, 1'b0);
    beat(700, 1'b1);
    step();
    chk("t1_done", 32'(done), 1);
    chk("t1_face", 32'(face), 0);
    chk("t1_fail", 32'(fail_stage), 1);
    step();
    chk("t1_idle", 32'(busy), 0);
    chk("t1_sscount", 32'(ss_cnt - ss0), 2);
    chk("t1_dcount", 32'(done_cnt - d0), 1);

    // 2: full accept, thresholds 211 + 1280*i (last = 27091)
    for (int i = 0; i < 22; i++) thr[i] = 24'(211 + 1280 * i);
    do_start();
    c0 = cyc;
    chk("t2_fail_clr", 32'(fail_stage), 0);
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("t2_stage%0d", i), 32'(stage_num), 32'(i));
      step();
      beat(30000, 1'b1);
      step();
    end
    chk("t2_done", 32'(done), 1);
    chk("t2_latency", 32'(cyc - c0), 66);
    chk("t2_face", 32'(face), 1);
    chk("t2_fail", 32'(fail_stage), 0);
    step();

    // 3: saturation at both rails
    thr[0] = 24'sd8388607;
    thr[1] = -24'sd8388607;
    do_start();
    step();
    beat(8000000, 1'b0);
    beat(8000000, 1'b1);
    step();
    chk("t3_pos_sat_pass", 32'(stage_num), 1);
    step();
    beat(-8000000, 1'b0);
    beat(-8000000, 1'b1);
    step();
    chk("t3_done", 32'(done), 1);
    chk("t3_neg_sat_fail", 32'(fail_stage), 1);
    chk("t3_face", 32'(face), 0);
    step();

    // 4: stalls; stalled beats carry -100 that must not be summed
    thr[0] = 24'sd11;
    thr[1] = 24'sd12;
    do_start();
    step();
    beat(5, 1'b0);
    wc_value = -24'sd100;
    step();
    chk("t4_stall_ready", 32'(wc_ready), 1);
    step();
    beat(6, 1'b1);
    chk("t4_cmp_ready", 32'(wc_ready), 0);
    wc_valid = 1'b1; wc_value = -24'sd1000; wc_last = 1'b1;
    step();
    wc_valid = 1'b0; wc_value = '0; wc_last = 1'b0;
    chk("t4_pass_11", 32'(stage_num), 1);
    step();
    beat(7, 1'b0);
    beat(4, 1'b1);
    step();
    chk("t4_done", 32'(done), 1);
    chk("t4_fail", 32'(fail_stage), 1);
    step();

    // 5: start while busy ignored, abort in ACCUM, abort in IDLE
    for (int i = 0; i < 32; i++) thr[i] = '0;
    d0 = done_cnt;
    do_start();
    pass_stages(3);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_start_ignored", 32'(stage_num), 3);
    beat(5, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_abort_busy", 32'(busy), 0);
    chk("t5_abort_done", 32'(done), 0);
    chk("t5_abort_face", 32'(face), 0);
    chk("t5_abort_fail", 32'(fail_stage), 0);
    repeat (4) step();
    chk("t5_no_done", 32'(done_cnt - d0), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5_idle_abort", 32'(busy), 0);
    thr[0] = 24'sd3;
    do_start();
    chk("t5_restart_stage", 32'(stage_num), 0);
    step();
    beat(2, 1'b1);
    step();
    chk("t5_restart_done", 32'(done), 1);
    chk("t5_restart_face", 32'(face), 0);
    step();

    // 6: async reset in stage 5 ACCUM, between clock edges
    thr[0] = '0;
    do_start();
    pass_stages(5);
    step();
    beat(3, 1'b0);
    chk("t6_pre_stage", 32'(stage_num), 5);
    #2;
    Reset = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    step();
    Reset = 1'b0;
    step();
    do_start();
    chk("t6_restart_ss", 32'(stage_start), 1);
    chk("t6_restart_stage", 32'(stage_num), 0);
    step();
    beat(1, 1'b1);
    step();
    chk("t6_restart_next", 32'(stage_num), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
